// File: rtl/yf_prog_loader.sv
// yf_prog_loader
// Receives a program image from a host over a byte stream and writes it into
// instruction memory, holding the CPU core in reset until the image has been
// loaded and its checksum verified.
//
// Frame: CNT_HI, CNT_LO (word count N, big-endian), N words of two bytes each
// (high byte first), then one checksum byte equal to the XOR of every byte
// before it, count bytes included.
//
// Byte stream handshake: a byte is transferred on a rising edge where
// in_valid and in_ready are both 1. in_ready depends only on the FSM state,
// never on in_valid, so the host may hold a byte on in_data for as long as it
// likes; a byte presented while in_ready is 0 is left untouched.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   host byte valid
//   in_data    host byte
//   in_ready   loader can take a byte this cycle
//   reload     single-cycle request: abandon everything and wait for a frame
//   mem_we     instruction-memory write strobe (registered)
//   mem_addr   instruction-memory word address (registered)
//   mem_wdata  instruction word {hi, lo} (registered)
//   cpu_rst    active-high CPU reset, released only once a load is good
//   done       load finished with a good checksum
//   err        load aborted on a checksum mismatch
//   fsm_state  current FSM state encoding, for observation
module yf_prog_loader #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          err,
  output logic [2:0]    fsm_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    WRITE   = 3'd4,
    CSUM    = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q;     // word count N taken from the frame header
  logic [15:0] words_q;   // words already written in this frame
  logic [15:0] words_nxt;
  logic [7:0]  hi_q;      // high byte of the word being assembled
  logic [7:0]  csum_q;    // running XOR of accepted frame bytes
  logic        take;

  assign take      = in_valid & in_ready;
  assign words_nxt = words_q + 16'd1;
  assign fsm_state = state_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    cpu_rst  = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (take) state_d = CNT_LO;
      end
      CNT_LO: begin
        in_ready = 1'b1;
        // An empty program goes straight to the checksum byte.
        if (take) state_d = ({cnt_q[15:8], in_data} == 16'd0) ? CSUM : DATA_HI;
      end
      DATA_HI: begin
        in_ready = 1'b1;
        if (take) state_d = DATA_LO;
      end
      DATA_LO: begin
        in_ready = 1'b1;
        if (take) state_d = WRITE;
      end
      WRITE: begin
        // words_q is at most N-1 here, so words_nxt never overflows,
        // which keeps N = 0xFFFF usable.
        state_d = (words_nxt == cnt_q) ? CSUM : DATA_HI;
      end
      CSUM: begin
        in_ready = 1'b1;
        if (take) state_d = (in_data == csum_q) ? DONE : ERR;
      end
      DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ERR: begin
        err = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // reload outranks everything, including a byte accepted this cycle.
    if (reload) state_d = IDLE;
  end

  // Datapath: header, word assembly, checksum and memory write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      words_q   <= '0;
      hi_q      <= '0;
      csum_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (reload) begin
      cnt_q    <= '0;
      words_q  <= '0;
      csum_q   <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_we <= 1'b0;
      if (take) csum_q <= csum_q ^ in_data;
      case (state_q)
        IDLE:    if (take) cnt_q[15:8] <= in_data;
        CNT_LO:  if (take) cnt_q[7:0]  <= in_data;
        DATA_HI: if (take) hi_q        <= in_data;
        DATA_LO: begin
          if (take) begin
            mem_we    <= 1'b1;
            mem_wdata <= DW'({hi_q, in_data});
          end
        end
        WRITE: begin
          // Address advances after the write; wraps naturally at 2^AW.
          mem_addr <= mem_addr + 1'b1;
          words_q  <= words_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_yf_prog_loader.sv
// Directed bench for yf_prog_loader.
module tb_yf_prog_loader;

  localparam int AW = 16;
  localparam int DW = 16;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          reload = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;
  logic [2:0]    fsm_state;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  yf_prog_loader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
    .done(done), .err(err), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard: every write must match the expected queue
  always @(negedge clk) begin
    if (rst === 1'b1 && mem_we === 1'b1) begin
      logic [AW+DW-1:0] e;
      wr_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: addr=%h data=%h, no write expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          n_bad++;
          $display("FAIL write: addr/data=%h_%h expected %h_%h", mem_addr, mem_wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int tries;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 20) begin
      acc = (in_ready === 1'b1);
      tries++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_vec++;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_byte: byte %h not accepted within 20 cycles", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit stall);
    int gap_tab[7] = '{2, 0, 3, 1, 0, 2, 1};
    for (int i = 0; i < f.size(); i++)
      send_byte(f[i], stall ? gap_tab[i % 7] : 0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if ({fsm_state, cpu_rst, mem_we, mem_addr, mem_wdata, done, err} !==
        {S_IDLE, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_outputs: st=%0d cpu_rst=%b we=%b addr=%h wd=%h done=%b err=%b, expected 0 1 0 0000 0000 0 0",
               fsm_state, cpu_rst, mem_we, mem_addr, mem_wdata, done, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || fsm_state !== S_IDLE) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b st=%0d expected 1 0", in_ready, fsm_state);
    end
  endtask

  // Checksum covers the count bytes: 00^02^14^01^40^12 = 45.
  task automatic test_basic();
    exp_q.push_back({16'h0000, 16'h1401});
    exp_q.push_back({16'h0001, 16'h4012});
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    n_vec++;
    if (fsm_state !== S_DATA_HI) begin
      n_bad++;
      $display("FAIL basic_hdr_state: st=%0d expected %0d", fsm_state, S_DATA_HI);
    end
    send_byte(8'h14, 0);
    send_byte(8'h01, 0);
    // One cycle after the low byte: the write strobe is up.
    n_vec++;
    if ({mem_we, in_ready, fsm_state, mem_addr, mem_wdata} !== {1'b1, 1'b0, S_WRITE, 16'h0000, 16'h1401}) begin
      n_bad++;
      $display("FAIL basic_write_latency: we=%b rdy=%b st=%0d addr=%h wd=%h expected 1 0 4 0000 1401",
               mem_we, in_ready, fsm_state, mem_addr, mem_wdata);
    end
    send_byte(8'h40, 0);
    send_byte(8'h12, 0);
    n_vec++;
    if (cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_pre_csum: cpu_rst=%b done=%b expected 1 0", cpu_rst, done);
    end
    send_byte(8'h45, 0);
    n_vec++;
    if ({cpu_rst, done, err, in_ready, fsm_state} !== {1'b0, 1'b1, 1'b0, 1'b0, S_DONE}) begin
      n_bad++;
      $display("FAIL basic_done: cpu_rst=%b done=%b err=%b rdy=%b st=%0d expected 0 1 0 0 6",
               cpu_rst, done, err, in_ready, fsm_state);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL basic_writes_pending: %0d writes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_empty();
    int w0;
    do_reload();
    w0 = wr_cnt;
    send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
    n_vec++;
    if ({done, cpu_rst, err} !== 3'b100 || wr_cnt != w0) begin
      n_bad++;
      $display("FAIL empty_frame: done=%b cpu_rst=%b err=%b writes=%0d expected 1 0 0 0",
               done, cpu_rst, err, wr_cnt - w0);
    end
    // Bytes offered in DONE are ignored and the state holds.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (fsm_state !== S_DONE || done !== 1'b1 || cpu_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL done_hold: st=%0d done=%b cpu_rst=%b expected 6 1 0", fsm_state, done, cpu_rst);
    end
    do_reload();
    n_vec++;
    if ({fsm_state, done, cpu_rst} !== {S_IDLE, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL done_reload: st=%0d done=%b cpu_rst=%b expected 0 0 1", fsm_state, done, cpu_rst);
    end
  endtask

  task automatic test_bad_csum();
    exp_q.push_back({16'h0000, 16'h1234});
    send_frame('{8'h00, 8'h01, 8'h12, 8'h34, 8'hFF}, 1'b0);
    n_vec++;
    if ({err, done, cpu_rst, in_ready, fsm_state} !== {1'b1, 1'b0, 1'b1, 1'b0, S_ERR} || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bad_csum: err=%b done=%b cpu_rst=%b rdy=%b st=%0d pend=%0d expected 1 0 1 0 7 0",
               err, done, cpu_rst, in_ready, fsm_state, exp_q.size());
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (err !== 1'b1 || cpu_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL err_hold: err=%b cpu_rst=%b expected 1 1", err, cpu_rst);
    end
    do_reload();
    n_vec++;
    if ({fsm_state, err, cpu_rst, in_ready} !== {S_IDLE, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL err_reload: st=%0d err=%b cpu_rst=%b rdy=%b expected 0 0 1 1", fsm_state, err, cpu_rst, in_ready);
    end
  endtask

  task automatic test_stalls();
    exp_q.push_back({16'h0000, 16'h1401});
    exp_q.push_back({16'h0001, 16'h4012});
    send_frame('{8'h00, 8'h02, 8'h14, 8'h01, 8'h40, 8'h12, 8'h45}, 1'b1);
    n_vec++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stall_frame: done=%b pend=%0d expected 1 0", done, exp_q.size());
    end
    do_reload();
  endtask

  task automatic test_reload_mid();
    int w0;
    w0 = wr_cnt;
    exp_q.push_back({16'h0000, 16'h1234});
    send_frame('{8'h00, 8'h03, 8'h12, 8'h34, 8'h56}, 1'b0);
    // reload together with an offered byte: the byte is dropped.
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h78;
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (fsm_state !== S_IDLE || wr_cnt - w0 != 1 || mem_addr !== 16'h0) begin
      n_bad++;
      $display("FAIL reload_mid: st=%0d writes=%0d addr=%h expected 0 1 0000", fsm_state, wr_cnt - w0, mem_addr);
    end
    exp_q.push_back({16'h0000, 16'hABCD});
    send_frame('{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h67}, 1'b0);
    n_vec++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reload_new_frame: done=%b pend=%0d expected 1 0", done, exp_q.size());
    end
    do_reload();
  endtask

  task automatic test_rst_in_write();
    exp_q.push_back({16'h0000, 16'h1401});
    send_frame('{8'h00, 8'h02, 8'h14, 8'h01, 8'h40}, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h12;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    n_vec++;
    if (fsm_state !== S_WRITE || mem_we !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_write_entry: st=%0d we=%b expected 4 1", fsm_state, mem_we);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({fsm_state, cpu_rst, mem_we, mem_addr, mem_wdata, done, err} !==
        {S_IDLE, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_in_write: st=%0d cpu_rst=%b we=%b addr=%h wd=%h done=%b err=%b expected 0 1 0 0000 0000 0 0",
               fsm_state, cpu_rst, mem_we, mem_addr, mem_wdata, done, err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back({16'h0000, 16'hABCD});
    send_frame('{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h67}, 1'b0);
    n_vec++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rst_next_frame: done=%b cpu_rst=%b pend=%0d expected 1 0 0", done, cpu_rst, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_bad_csum();
    test_stalls();
    test_reload_mid();
    test_rst_in_write();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
